hazard_scoreboard: RTL and testbench

- Parametrised successor to the stage-local stall/forward logic of the 5-stage pipeline.
- Holds its own scoreboard of in-flight destinations (E, M, W) with per-stage Tnew countdown, so only D-stage decode info is needed.
- Owns the mult/div busy countdown that was previously supplied externally.
- Drives the stall signal and all D/E/M forwarding selects.

---
 rtl/hazard_pkg.sv | 23 ++
 rtl/hazard_md_busy.sv | 26 ++
 rtl/hazard_scoreboard.sv | 120 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard scoreboard: forwarding select codes,
// the per-stage destination record and the default mult/div latencies.
package hazard_pkg;
  localparam int SB_REG_AW    = 5;
  localparam int SB_TNEW_W    = 2;
  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_OLD  = 2'b01;
  localparam logic [1:0] FWD_NEW  = 2'b10;

  typedef struct packed {
    logic [SB_REG_AW-1:0] dst;
    logic                 we;
    logic [SB_TNEW_W-1:0] tnew;
  } stage_ent_t;

  // Tnew counts down as the producer advances, but never wraps below zero.
  function automatic logic [SB_TNEW_W-1:0] tnew_dec(input logic [SB_TNEW_W-1:0] t);
    return (t == '0) ? t : t - SB_TNEW_W'(1);
  endfunction
endpackage

// File: rtl/hazard_md_busy.sv
// Mult/div busy countdown and the HI/LO stall term. Loads when a mult/div sits in E,
// then counts down; a HI/LO user in D stalls while busy or while the op is still in E.
module hazard_md_busy import hazard_pkg::*; #(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int CNT_W    = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_e_md_start,
  input  logic i_e_md_div,
  input  logic i_md_use_d,
  output logic o_md_busy,
  output logic o_md_stall
);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            r_cnt <= '0;
    else if (i_e_md_start) r_cnt <= i_e_md_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
    else if (r_cnt != '0)  r_cnt <= r_cnt - CNT_W'(1);
  end

  assign o_md_busy  = (r_cnt != '0);
  assign o_md_stall = i_md_use_d & (o_md_busy | i_e_md_start);
endmodule

// File: rtl/hazard_scoreboard.sv
// Stall / forwarding unit with its own E/M/W destination scoreboard.
// Build option HAZ_PERF_EN adds stall_cnt and md_stall_cnt performance counters.
module hazard_scoreboard import hazard_pkg::*; #(
  parameter int REG_AW   = SB_REG_AW,
  parameter int TNEW_W   = SB_TNEW_W,
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int CNT_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic [TNEW_W-1:0] rs_tuse,
  input  logic [TNEW_W-1:0] rt_tuse,
  input  logic [REG_AW-1:0] dst_d,
  input  logic              we_d,
  input  logic [TNEW_W-1:0] tnew_d,
  input  logic              md_start_d,
  input  logic              md_div_d,
  input  logic              md_use_d,
  output logic              stall,
  output logic [1:0]        fwd_rs_d,
  output logic [1:0]        fwd_rt_d,
  output logic [1:0]        fwd_rs_e,
  output logic [1:0]        fwd_rt_e,
  output logic              fwd_rt_m,
  output logic              md_busy
`ifdef HAZ_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       md_stall_cnt
`endif
);
  localparam int NSRC = 2;  // index 0 = rs, 1 = rt

  stage_ent_t        r_e, r_m, r_w;
  logic [REG_AW-1:0] r_e_rs, r_e_rt, r_m_rt;
  logic              r_e_md_start, r_e_md_div;

  logic [NSRC-1:0][REG_AW-1:0] w_src_d, w_src_e;
  logic [NSRC-1:0][TNEW_W-1:0] w_tuse;
  logic [NSRC-1:0][1:0]        w_fwd_d, w_fwd_e;
  logic [NSRC-1:0]             w_hold;
  logic                        w_md_stall, w_stall;

  function automatic logic hit(input logic [REG_AW-1:0] r, input stage_ent_t s);
    return (r != '0) && s.we && (r == s.dst);
  endfunction

  assign w_src_d = {rt_d, rs_d};
  assign w_src_e = {r_e_rt, r_e_rs};
  assign w_tuse  = {rt_tuse, rs_tuse};

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    assign w_hold[g] = (hit(w_src_d[g], r_e) && (w_tuse[g] < r_e.tnew)) ||
                       (hit(w_src_d[g], r_m) && (w_tuse[g] < r_m.tnew));
    // The younger producer in E wins over M.
    assign w_fwd_d[g] = (hit(w_src_d[g], r_e) && (r_e.tnew == '0)) ? FWD_NEW :
                        (hit(w_src_d[g], r_m) && (r_m.tnew == '0)) ? FWD_OLD : FWD_NONE;
    assign w_fwd_e[g] = (hit(w_src_e[g], r_m) && (r_m.tnew == '0)) ? FWD_NEW :
                        (hit(w_src_e[g], r_w) && (r_w.tnew == '0)) ? FWD_OLD : FWD_NONE;
  end

  hazard_md_busy #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) u_md_busy (
    .clk          (clk),
    .reset        (reset),
    .i_e_md_start (r_e_md_start),
    .i_e_md_div   (r_e_md_div),
    .i_md_use_d   (md_use_d),
    .o_md_busy    (md_busy),
    .o_md_stall   (w_md_stall)
  );

  assign w_stall  = (|w_hold) | w_md_stall;
  assign stall    = w_stall;
  assign fwd_rs_d = w_fwd_d[0];
  assign fwd_rt_d = w_fwd_d[1];
  assign fwd_rs_e = w_fwd_e[0];
  assign fwd_rt_e = w_fwd_e[1];
  assign fwd_rt_m = hit(r_m_rt, r_w) && (r_w.tnew == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_e <= '0; r_m <= '0; r_w <= '0;
      r_e_rs <= '0; r_e_rt <= '0; r_m_rt <= '0;
      r_e_md_start <= 1'b0; r_e_md_div <= 1'b0;
    end else begin
      r_w    <= r_m;
      r_m    <= '{dst: r_e.dst, we: r_e.we, tnew: tnew_dec(r_e.tnew)};
      r_m_rt <= r_e_rt;
      if (w_stall) begin
        r_e <= '0; r_e_rs <= '0; r_e_rt <= '0;
        r_e_md_start <= 1'b0; r_e_md_div <= 1'b0;
      end else begin
        r_e <= '{dst: dst_d, we: we_d, tnew: tnew_d};
        r_e_rs <= rs_d; r_e_rt <= rt_d;
        r_e_md_start <= md_start_d; r_e_md_div <= md_div_d;
      end
    end
  end

`ifdef HAZ_PERF_EN
  logic [31:0] r_stall_cnt, r_md_stall_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt    <= '0;
      r_md_stall_cnt <= '0;
    end else begin
      if (w_stall) r_stall_cnt <= r_stall_cnt + 32'd1;
      // Only stalls that the HI/LO rule alone is responsible for.
      if (w_md_stall && !(|w_hold)) r_md_stall_cnt <= r_md_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt    = r_stall_cnt;
  assign md_stall_cnt = r_md_stall_cnt;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed pipeline scenarios plus randomized traffic
// checked against an instruction-level model of the E/M/W pipe and the mult/div unit.
module tb_hazard_scoreboard;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] rs_d, rt_d, dst_d;
  logic [1:0] rs_tuse, rt_tuse, tnew_d;
  logic       we_d, md_start_d, md_div_d, md_use_d;
  logic       stall, fwd_rt_m, md_busy;
  logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
`ifdef HAZ_PERF_EN
  logic [31:0] stall_cnt, md_stall_cnt;
`endif

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .reset(reset),
    .rs_d(rs_d), .rt_d(rt_d), .rs_tuse(rs_tuse), .rt_tuse(rt_tuse),
    .dst_d(dst_d), .we_d(we_d), .tnew_d(tnew_d),
    .md_start_d(md_start_d), .md_div_d(md_div_d), .md_use_d(md_use_d),
    .stall(stall), .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
    .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e), .fwd_rt_m(fwd_rt_m),
    .md_busy(md_busy)
`ifdef HAZ_PERF_EN
    , .stall_cnt(stall_cnt), .md_stall_cnt(md_stall_cnt)
`endif
  );

  task automatic set_d(input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] rsu,
                       input logic [1:0] rtu, input logic [4:0] dst, input logic we,
                       input logic [1:0] tn, input logic mds, input logic mdd, input logic mdu);
    rs_d = rs; rt_d = rt; rs_tuse = rsu; rt_tuse = rtu; dst_d = dst; we_d = we;
    tnew_d = tn; md_start_d = mds; md_div_d = mdd; md_use_d = mdu;
  endtask

  task automatic nop();
    set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    @(negedge clk); reset = 1'b0; nop();
    @(negedge clk); reset = 1'b1;
  endtask

  // Holds a HI/LO reader in D behind a mult/div and reports how long it stalled.
  task automatic run_md(input logic div, output int n_stall, output logic busy_at_release);
    n_stall = 0; busy_at_release = 1'b1;
    set_d(0, 0, 0, 0, 0, 0, 0, 1, div, 1);
    tick();
    set_d(0, 0, 0, 0, 5'd2, 1, 2'd1, 0, 0, 1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!stall) begin busy_at_release = md_busy; break; end
      n_stall++;
      tick();
    end
    tick(); nop();
  endtask

  task automatic test_reset();
    @(negedge clk); reset = 1'b0;
    set_d(5'd3, 5'd3, 0, 0, 5'd3, 1, 2'd2, 1, 1, 1);
    tick(); tick(); @(negedge clk);
    n_total++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b exp 0", stall); else n_pass++;
    n_total++; if ({fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m} !== 9'd0)
      $display("FAIL reset_fwd: got %b exp 0", {fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m});
    else n_pass++;
    n_total++; if (md_busy !== 1'b0) $display("FAIL reset_busy: got %b exp 0", md_busy); else n_pass++;
    reset = 1'b1; nop();
  endtask

  task automatic test_load_use();
    apply_reset();
    set_d(5'd1, 0, 0, 0, 5'd3, 1, 2'd2, 0, 0, 0);
    tick();
    set_d(5'd3, 5'd4, 2'd1, 2'd1, 5'd6, 1, 2'd1, 0, 0, 0);
    @(negedge clk);
    n_total++; if (stall !== 1'b1) $display("FAIL lu_stall1: got %b exp 1", stall); else n_pass++;
    tick(); @(negedge clk);
    n_total++; if (stall !== 1'b0) $display("FAIL lu_stall2: got %b exp 0", stall); else n_pass++;
    n_total++; if (fwd_rs_d !== 2'b00) $display("FAIL lu_fwd_rs_d: got %b exp 00", fwd_rs_d); else n_pass++;
    tick(); nop();
  endtask

  task automatic test_alu_b2b();
    apply_reset();
    set_d(0, 0, 0, 0, 5'd5, 1, 2'd1, 0, 0, 0);
    tick();
    set_d(5'd5, 5'd0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_total++; if (stall !== 1'b1) $display("FAIL b2b_stall1: got %b exp 1", stall); else n_pass++;
    tick(); @(negedge clk);
    n_total++; if (stall !== 1'b0) $display("FAIL b2b_stall2: got %b exp 0", stall); else n_pass++;
    n_total++; if (fwd_rs_d !== 2'b01) $display("FAIL b2b_fwd_rs_d: got %b exp 01", fwd_rs_d); else n_pass++;
    n_total++; if (fwd_rt_d !== 2'b00) $display("FAIL b2b_fwd_rt_d: got %b exp 00", fwd_rt_d); else n_pass++;
    tick(); nop(); @(negedge clk);
    n_total++; if (fwd_rs_e !== 2'b01) $display("FAIL b2b_fwd_rs_e: got %b exp 01", fwd_rs_e); else n_pass++;
    // A writer of $0 is never a hazard.
    apply_reset();
    set_d(0, 0, 0, 0, 5'd0, 1, 2'd2, 0, 0, 0);
    tick();
    set_d(5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_total++; if ({stall, fwd_rs_d, fwd_rt_d} !== 5'd0)
      $display("FAIL zero_reg: got %b exp 00000", {stall, fwd_rs_d, fwd_rt_d});
    else n_pass++;
    tick(); nop();
  endtask

  task automatic test_priority();
    apply_reset();
    set_d(0, 0, 0, 0, 5'd8, 1, 2'd0, 0, 0, 0); tick();
    set_d(0, 0, 0, 0, 5'd8, 1, 2'd0, 0, 0, 0); tick();
    set_d(5'd8, 5'd8, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_total++; if (fwd_rs_d !== 2'b10) $display("FAIL prio_rs_d: got %b exp 10", fwd_rs_d); else n_pass++;
    n_total++; if (stall !== 1'b0) $display("FAIL prio_stall: got %b exp 0", stall); else n_pass++;
    apply_reset();
    set_d(0, 0, 0, 0, 5'd9, 1, 2'd0, 0, 0, 0); tick();
    set_d(5'd1, 5'd9, 2'd1, 2'd2, 0, 0, 0, 0, 0, 0); tick();
    nop(); @(negedge clk);
    n_total++; if (fwd_rt_e !== 2'b10) $display("FAIL prio_rt_e: got %b exp 10", fwd_rt_e); else n_pass++;
    tick(); @(negedge clk);
    n_total++; if (fwd_rt_m !== 1'b1) $display("FAIL store_rt_m: got %b exp 1", fwd_rt_m); else n_pass++;
    tick();
  endtask

  task automatic test_mult_div();
    int n; logic b;
    apply_reset();
    run_md(1'b0, n, b);
    n_total++; if (n != 6) $display("FAIL mult_stall_len: got %0d exp 6", n); else n_pass++;
    n_total++; if (b !== 1'b0) $display("FAIL mult_busy_release: got %b exp 0", b); else n_pass++;
    run_md(1'b1, n, b);
    n_total++; if (n != 11) $display("FAIL div_stall_len: got %0d exp 11", n); else n_pass++;
    n_total++; if (b !== 1'b0) $display("FAIL div_busy_release: got %b exp 0", b); else n_pass++;
  endtask

  task automatic test_reset_mid_div();
    apply_reset();
    set_d(0, 0, 0, 0, 0, 0, 0, 1, 1, 1); tick();
    set_d(0, 0, 0, 0, 5'd2, 1, 2'd1, 0, 0, 1);
    repeat (4) tick();
    @(negedge clk);
    n_total++; if (md_busy !== 1'b1) $display("FAIL mid_div_busy: got %b exp 1", md_busy); else n_pass++;
    tick(); reset = 1'b0; #1;
    n_total++; if ({md_busy, stall} !== 2'b00) $display("FAIL mid_div_rst: got %b exp 00", {md_busy, stall}); else n_pass++;
    n_total++; if ({fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m} !== 9'd0)
      $display("FAIL mid_div_rst_fwd: got %b exp 0", {fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m});
    else n_pass++;
    @(negedge clk); reset = 1'b1; #1;
    n_total++; if (stall !== 1'b0) $display("FAIL post_rst_issue: got %b exp 0", stall); else n_pass++;
    tick(); nop();
  endtask

`ifdef HAZ_PERF_EN
  task automatic test_perf();
    int n; logic b;
    apply_reset();
    set_d(5'd1, 0, 0, 0, 5'd3, 1, 2'd2, 0, 0, 0); tick();
    set_d(5'd3, 5'd4, 2'd1, 2'd1, 5'd6, 1, 2'd1, 0, 0, 0); tick(); tick();
    nop(); tick(); tick();
    run_md(1'b0, n, b);
    @(negedge clk);
    n_total++; if (stall_cnt !== 32'd7) $display("FAIL perf_stall_cnt: got %0d exp 7", stall_cnt); else n_pass++;
    n_total++; if (md_stall_cnt !== 32'd6) $display("FAIL perf_md_cnt: got %0d exp 6", md_stall_cnt); else n_pass++;
  endtask
`endif

  // Instruction-level reference: each stage holds the instruction occupying it.
  typedef struct {
    int dst; bit we; int tnew; int rs; int rt; bit mds; bit mdd;
  } ins_t;

  function automatic bit mhit(input int r, input ins_t s);
    return (r != 0) && s.we && (r == s.dst);
  endfunction

  task automatic test_random();
    ins_t pe, pm, pw, bub, din;
    int cyc, md_ls, md_lat, tm, tw, e_fd_rs, e_fd_rt, e_fe_rs, e_fe_rt, n_st, n_md;
    bit e_stall, e_busy, e_frm, hold, mdst;
    bub = '{0, 0, 0, 0, 0, 0, 0};
    pe = bub; pm = bub; pw = bub;
    cyc = 0; md_ls = -100; md_lat = 0; n_st = 0; n_md = 0;
    apply_reset();
    for (int k = 0; k < 2000; k++) begin
      din.rs = $urandom_range(3); din.rt = $urandom_range(3); din.dst = $urandom_range(3);
      din.we = ($urandom_range(3) != 0); din.tnew = $urandom_range(2);
      din.mds = ($urandom_range(15) == 0); din.mdd = $urandom_range(1);
      set_d(5'(din.rs), 5'(din.rt), 2'($urandom_range(2)), 2'($urandom_range(2)), 5'(din.dst),
            din.we, 2'(din.tnew), din.mds, din.mdd, din.mds | ($urandom_range(7) == 0));
      @(negedge clk);
      tm = (pm.tnew > 0) ? pm.tnew - 1 : 0;
      tw = (pw.tnew > 0) ? pw.tnew - 1 : 0;
      e_busy = (cyc > md_ls) && (cyc <= md_ls + md_lat);
      hold = (mhit(din.rs, pe) && int'(rs_tuse) < pe.tnew) || (mhit(din.rt, pe) && int'(rt_tuse) < pe.tnew) ||
             (mhit(din.rs, pm) && int'(rs_tuse) < tm) || (mhit(din.rt, pm) && int'(rt_tuse) < tm);
      mdst = md_use_d && (e_busy || pe.mds);
      e_stall = hold || mdst;
      e_fd_rs = (mhit(din.rs, pe) && pe.tnew == 0) ? 2 : (mhit(din.rs, pm) && tm == 0) ? 1 : 0;
      e_fd_rt = (mhit(din.rt, pe) && pe.tnew == 0) ? 2 : (mhit(din.rt, pm) && tm == 0) ? 1 : 0;
      e_fe_rs = (mhit(pe.rs, pm) && tm == 0) ? 2 : (mhit(pe.rs, pw) && tw == 0) ? 1 : 0;
      e_fe_rt = (mhit(pe.rt, pm) && tm == 0) ? 2 : (mhit(pe.rt, pw) && tw == 0) ? 1 : 0;
      e_frm = mhit(pm.rt, pw) && tw == 0;
      n_total++; if (stall !== e_stall) $display("FAIL rnd_stall c%0d: got %b exp %b", k, stall, e_stall); else n_pass++;
      n_total++; if ({fwd_rs_d, fwd_rt_d} !== {2'(e_fd_rs), 2'(e_fd_rt)})
        $display("FAIL rnd_fwd_d c%0d: got %b exp %b", k, {fwd_rs_d, fwd_rt_d}, {2'(e_fd_rs), 2'(e_fd_rt)});
      else n_pass++;
      n_total++; if ({fwd_rs_e, fwd_rt_e} !== {2'(e_fe_rs), 2'(e_fe_rt)})
        $display("FAIL rnd_fwd_e c%0d: got %b exp %b", k, {fwd_rs_e, fwd_rt_e}, {2'(e_fe_rs), 2'(e_fe_rt)});
      else n_pass++;
      n_total++; if (fwd_rt_m !== e_frm) $display("FAIL rnd_fwd_m c%0d: got %b exp %b", k, fwd_rt_m, e_frm); else n_pass++;
      n_total++; if (md_busy !== e_busy) $display("FAIL rnd_busy c%0d: got %b exp %b", k, md_busy, e_busy); else n_pass++;
      if (e_stall) n_st++;
      if (mdst && !hold) n_md++;
      if (pe.mds) begin md_ls = cyc; md_lat = pe.mdd ? 10 : 5; end
      pw = pm; pm = pe; pe = e_stall ? bub : din;
      cyc++;
      tick();
    end
`ifdef HAZ_PERF_EN
    @(negedge clk);
    n_total++; if (stall_cnt !== 32'(n_st)) $display("FAIL rnd_stall_cnt: got %0d exp %0d", stall_cnt, n_st); else n_pass++;
    n_total++; if (md_stall_cnt !== 32'(n_md)) $display("FAIL rnd_md_cnt: got %0d exp %0d", md_stall_cnt, n_md); else n_pass++;
`endif
    nop();
  endtask

  initial begin
    nop();
    test_reset();
    test_load_use();
    test_alu_b2b();
    test_priority();
    test_mult_div();
    test_reset_mid_div();
`ifdef HAZ_PERF_EN
    test_perf();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
